// File: rtl/sm_bcd_disp.sv
// sm_bcd_disp: sign-magnitude to signed decimal seven-segment display driver.
//
// Captures an N-bit sign-magnitude word, converts the magnitude to three BCD
// digits with a sequential shift-add-3 (double-dabble) FSM, then drives a
// time-multiplexed 4-digit common-anode display with the signed value.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   sum_in     N-bit sign-magnitude value (bit N-1 = sign)
//   load       capture request, honoured only in IDLE
//   busy       high while converting (CONV) and publishing (DONE)
//   done_tick  one-cycle pulse as the new value is written to the display regs
//   an         digit enables, active-low, an[3] = leftmost digit
//   sseg       segments, active-low, {dp,g,f,e,d,c,b,a}
//
// Optional feature: define SM_BCD_DISP_BLANK_EN for leading-zero blanking of
// the hundreds and tens digits. Without it all three digits are always shown.

module sm_bcd_disp #(
    parameter int N            = 8,
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     sum_in,
    input  logic             load,
    output logic             busy,
    output logic             done_tick,
    output logic [3:0]       an,
    output logic [7:0]       sseg
);

    localparam int MW = N - 1;  // magnitude width

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           mag_q, mag_d;
    logic                    sign_q, sign_d;
    logic [11:0]             bcd_q, bcd_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [11:0]             disp_bcd_q, disp_bcd_d;
    logic                    disp_sign_q, disp_sign_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    logic [11:0]             bcd_adj;
    logic [1:0]              digit_sel;
    logic [6:0]              seg7;
    logic                    blank_hund, blank_tens;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied before each shift so a digit >= 5 carries
    // into the next digit once doubled.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        disp_bcd_d  = disp_bcd_q;
        disp_sign_d = disp_sign_q;
        done_tick   = 1'b0;
        busy        = (state_q != IDLE);
        refresh_d   = refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};

        case (state_q)
            IDLE: begin
                if (load) begin
                    mag_d   = sum_in[N-2:0];
                    sign_d  = sum_in[N-1];
                    bcd_d   = '0;
                    cnt_d   = 4'(N - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[10:0], mag_q[MW-1]};
                mag_d = {mag_q[MW-2:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                disp_bcd_d  = bcd_q;
                // Negative zero is shown as plain 0.
                disp_sign_d = sign_q & (bcd_q != 12'd0);
                done_tick   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            disp_bcd_q  <= '0;
            disp_sign_q <= 1'b0;
            refresh_q   <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_sign_q <= disp_sign_d;
            refresh_q   <= refresh_d;
        end
    end

`ifdef SM_BCD_DISP_BLANK_EN
    assign blank_hund = (disp_bcd_q[11:8] == 4'd0);
    assign blank_tens = blank_hund && (disp_bcd_q[7:4] == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        an             = 4'b1111;
        an[digit_sel]  = 1'b0;
        case (digit_sel)
            2'd0:    seg7 = seg_of(disp_bcd_q[3:0]);
            2'd1:    seg7 = blank_tens ? SEG_BLANK : seg_of(disp_bcd_q[7:4]);
            2'd2:    seg7 = blank_hund ? SEG_BLANK : seg_of(disp_bcd_q[11:8]);
            default: seg7 = disp_sign_q ? SEG_MINUS : SEG_BLANK;
        endcase
        sseg = {1'b1, seg7};
        // Dark display for as long as reset is held, not just after an edge.
        if (!reset_n) begin
            an   = 4'b1111;
            sseg = 8'hFF;
        end
    end

endmodule

// File: tb/tb_sm_bcd_disp.sv
module tb_sm_bcd_disp;

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S4 = 8'h99,
                           S5 = 8'h92, S7 = 8'hF8, S9 = 8'h90,
                           SMIN = 8'hBF, SBLK = 8'hFF;
`ifdef SM_BCD_DISP_BLANK_EN
    localparam logic [7:0] LZ = SBLK;  // leading zero digit
`else
    localparam logic [7:0] LZ = S0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sum_in;
    logic       load;
    logic       busy, done_tick;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;

    sm_bcd_disp #(.N(8), .REFRESH_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .load(load),
        .busy(busy), .done_tick(done_tick), .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the first negedge after the capture edge.
    task automatic do_load(input logic [7:0] v);
        sum_in = v;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load   = 1'b0;
        sum_in = 8'h00;
    endtask

    // Samples 20 negedges starting at the current one.
    task automatic run_conv(output int lat, output int busy_cnt, output int ticks);
        lat = -1; busy_cnt = 0; ticks = 0;
        for (int j = 1; j <= 20; j++) begin
            if (busy) busy_cnt++;
            if (done_tick) begin
                ticks++;
                if (lat < 0) lat = j;
            end
            @(negedge clk);
        end
    endtask

    // One full refresh period; seg[d] is what digit d showed.
    task automatic read_display(output logic [3:0][7:0] seg, output int bad_an);
        seg = '1; bad_an = 0;
        for (int j = 0; j < 16; j++) begin
            case (an)
                4'b1110: seg[0] = sseg;
                4'b1101: seg[1] = sseg;
                4'b1011: seg[2] = sseg;
                4'b0111: seg[3] = sseg;
                default: bad_an++;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [3:0][7:0] seg, exp;
        int bad;
        reset_n = 1'b0; load = 1'b0; sum_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg got %h want ff", sseg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_tick); end
        reset_n = 1'b1;
        #1;
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_an got %b want 1110", an); end
        checks++; if (sseg !== S0) begin errors++; $display("FAIL release_sseg got %h want %h", sseg, S0); end
        @(negedge clk);
        read_display(seg, bad);
        exp = {SBLK, LZ, LZ, S0};
        for (int d = 0; d < 4; d++) begin
            checks++; if (seg[d] !== exp[d]) begin errors++; $display("FAIL reset_digit%0d got %h want %h", d, seg[d], exp[d]); end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_an_onehot got %0d bad want 0", bad); end
    endtask

    task automatic test_value(input string name, input logic [7:0] v,
                              input logic [3:0][7:0] exp);
        logic [3:0][7:0] seg;
        int lat, bc, tk, bad;
        do_load(v);
        run_conv(lat, bc, tk);
        checks++; if (lat !== 8) begin errors++; $display("FAIL %s_latency got %0d want 8", name, lat); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL %s_busy_cycles got %0d want 8", name, bc); end
        checks++; if (tk !== 1) begin errors++; $display("FAIL %s_ticks got %0d want 1", name, tk); end
        read_display(seg, bad);
        for (int d = 0; d < 4; d++) begin
            checks++; if (seg[d] !== exp[d]) begin errors++; $display("FAIL %s_digit%0d got %h want %h", name, d, seg[d], exp[d]); end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL %s_an_onehot got %0d bad want 0", name, bad); end
    endtask

    task automatic test_positive();
        test_value("pos5", 8'h05, {SBLK, LZ, LZ, S5});
    endtask

    task automatic test_max_negative();
        test_value("neg127", 8'hFF, {SMIN, S1, S2, S7});
        test_value("neg12", 8'h8C, {SMIN, LZ, S1, S2});
    endtask

    task automatic test_neg_zero();
        test_value("negzero", 8'h80, {SBLK, LZ, LZ, S0});
    endtask

    task automatic test_back_to_back();
        logic [3:0][7:0] seg, exp;
        int tk, bad, waited;
        do_load(8'h2A);
        repeat (2) @(negedge clk);
        do_load(8'h63);          // third cycle of conversion: must be ignored
        tk = 0;
        for (int j = 0; j < 20; j++) begin
            if (done_tick) tk++;
            @(negedge clk);
        end
        checks++; if (tk !== 1) begin errors++; $display("FAIL busy_load_ticks got %0d want 1", tk); end
        read_display(seg, bad);
        exp = {SBLK, LZ, S4, S2};
        for (int d = 0; d < 4; d++) begin
            checks++; if (seg[d] !== exp[d]) begin errors++; $display("FAIL busy_load_digit%0d got %h want %h", d, seg[d], exp[d]); end
        end
        // New load accepted in the cycle right after DONE.
        do_load(8'h2A);
        waited = 0;
        while (!done_tick && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (done_tick !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done_tick); end
        @(negedge clk);
        do_load(8'h63);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        repeat (12) @(negedge clk);
        read_display(seg, bad);
        exp = {SBLK, LZ, S9, S9};
        for (int d = 0; d < 4; d++) begin
            checks++; if (seg[d] !== exp[d]) begin errors++; $display("FAIL b2b_digit%0d got %h want %h", d, seg[d], exp[d]); end
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [3:0][7:0] seg, exp;
        int tk, bad;
        do_load(8'hFF);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL midrst_an got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL midrst_sseg got %h want ff", sseg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tk = 0;
        for (int j = 0; j < 20; j++) begin
            if (done_tick) tk++;
            @(negedge clk);
        end
        checks++; if (tk !== 0) begin errors++; $display("FAIL midrst_ticks got %0d want 0", tk); end
        read_display(seg, bad);
        exp = {SBLK, LZ, LZ, S0};
        for (int d = 0; d < 4; d++) begin
            checks++; if (seg[d] !== exp[d]) begin errors++; $display("FAIL midrst_digit%0d got %h want %h", d, seg[d], exp[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_max_negative();
        test_neg_zero();
        test_back_to_back();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
